// File: rtl/fifo_stream_reader_if.sv
// Read-side FIFO port plus valid/ready stream port of fifo_stream_reader.
// master = the reader stage, slave = the FIFO/downstream environment.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty_in;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_read_out;
  logic             m_valid_out;
  logic             m_ready_in;
  logic [WIDTH-1:0] m_data_out;

  modport master (
    input  fifo_empty_in,
    input  fifo_data_in,
    input  m_ready_in,
    output fifo_read_out,
    output m_valid_out,
    output m_data_out
  );

  modport slave (
    output fifo_empty_in,
    output fifo_data_in,
    output m_ready_in,
    input  fifo_read_out,
    input  m_valid_out,
    input  m_data_out
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Async-FIFO read-side consumer: hides the 1-cycle read latency behind a 2-entry buffer.
// Optional macro FIFO_STREAM_READER_CNT_EN adds word_cnt_out, a 32-bit count of completed pops.
module fifo_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [31:0]          word_cnt_out
`endif
);

  // State encoding equals the number of buffered words.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             inflight_r;
  logic             valid_r;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic [WIDTH-1:0] tail_r;
  logic [WIDTH-1:0] tail_nxt_s;
  logic             pop_s;
  logic             capture_s;
  logic             read_s;
  logic [2:0]       pending_s;

  if (SKID_DEPTH != 2) begin : g_depth_check
    $error("fifo_stream_reader: SKID_DEPTH must be 2");
  end

  assign pop_s     = valid_r & bus.m_ready_in;
  assign capture_s = inflight_r;

  // Words that will be held after this edge; never exceeds 2 when reads obey it.
  assign pending_s = {1'b0, state_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign read_s    = nrst_in & ~bus.fifo_empty_in & (pending_s < 3'd2);

  assign bus.fifo_read_out = read_s;
  assign bus.m_valid_out   = valid_r;
  assign bus.m_data_out    = head_r;

  // Next-state and buffer shifting on capture/pop.
  always_comb begin
    state_nxt_s = state_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    case (state_r)
      EMPTY: begin
        if (capture_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = bus.fifo_data_in;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (capture_s && !pop_s) begin
          state_nxt_s = TWO;
          tail_nxt_s  = bus.fifo_data_in;
        end else if (!capture_s && pop_s) begin
          state_nxt_s = EMPTY;
        end else if (capture_s && pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = bus.fifo_data_in;
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        if (pop_s && capture_s) begin
          state_nxt_s = TWO;
          head_nxt_s  = tail_r;
          tail_nxt_s  = bus.fifo_data_in;
        end else if (pop_s) begin
          state_nxt_s = ONE;
          head_nxt_s  = tail_r;
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
    valid_nxt_s = (state_nxt_s != EMPTY);
  end

  // Buffer, state and in-flight read registers.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_r    <= EMPTY;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      head_r     <= {WIDTH{1'b0}};
      tail_r     <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= read_s;
      valid_r    <= valid_nxt_s;
      head_r     <= head_nxt_s;
      tail_r     <= tail_nxt_s;
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [31:0] word_cnt_r;

  // Completed-pop counter, wraps naturally at 2^32.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      word_cnt_r <= 32'd0;
    end else if (pop_s) begin
      word_cnt_r <= word_cnt_r + 32'd1;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign word_cnt_out = word_cnt_r;
`endif

  fifo_stream_reader_chk u_chk (
    .clk        (clk_in),
    .nrst       (nrst_in),
    .in_two     (state_r == TWO),
    .capture    (capture_s),
    .pop        (pop_s),
    .read       (read_s),
    .fifo_empty (bus.fifo_empty_in)
  );

endmodule

// Simulation-only invariants of the reader buffer.
module fifo_stream_reader_chk (
  input logic clk,
  input logic nrst,
  input logic in_two,
  input logic capture,
  input logic pop,
  input logic read,
  input logic fifo_empty
);
  a_no_overfill: assert property (@(posedge clk) disable iff (!nrst)
    !(in_two && capture && !pop));
  a_no_empty_read: assert property (@(posedge clk) disable iff (!nrst)
    !(read && fifo_empty));
endmodule
